// File: rtl/pri_codec_pkg.sv
// Shared types and golden decode for the 3-bit request codec.
// Code k sets bit k of the request vector; code 0 means no request.
package pri_codec_pkg;

  localparam int CODEW = 3;
  localparam int NREQ  = 7;

  typedef logic [CODEW-1:0] code_t;
  typedef logic [NREQ:1]    req_t;

  function automatic req_t decode_code(code_t code);
    req_t r;
    r = '0;
    for (int k = 1; k <= NREQ; k++) begin
      r[k] = (code == CODEW'(k));
    end
    return r;
  endfunction

endpackage

// File: rtl/onehot_decoder.sv
// Combinational 3-to-7 one-hot decoder, gate-level like the encoder.
// Code 0 yields an all-zero vector.
module onehot_decoder
  import pri_codec_pkg::*;
(
  input  code_t code_i,
  output req_t  req_o
);

  code_t n;

  assign n = ~code_i;

  assign req_o[1] = n[2]      & n[1]      & code_i[0];
  assign req_o[2] = n[2]      & code_i[1] & n[0];
  assign req_o[3] = n[2]      & code_i[1] & code_i[0];
  assign req_o[4] = code_i[2] & n[1]      & n[0];
  assign req_o[5] = code_i[2] & n[1]      & code_i[0];
  assign req_o[6] = code_i[2] & code_i[1] & n[0];
  assign req_o[7] = code_i[2] & code_i[1] & code_i[0];

endmodule

// File: rtl/priority_decoder_fifo.sv
// Buffered request decoder: FIFO of 3-bit codes, one-hot head output,
// and a saturating count of delivered non-zero requests.
module priority_decoder_fifo
  import pri_codec_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNTW  = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  input  logic [2:0]      in_code,
  output logic            in_ready,
  output logic            out_valid,
  output logic [7:1]      out_a,
  input  logic            out_ready,
  output logic [CNTW-1:0] req_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  code_t            mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic [CNTW-1:0]  req_q, req_d;
  logic             push, pop;
  code_t            head;
  req_t             head_dec;

  assign in_ready  = !reset && (cnt_q < FULL);
  assign out_valid = !reset && (cnt_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign head      = mem_q[rd_q];

  onehot_decoder u_dec (
    .code_i (head),
    .req_o  (head_dec)
  );

  // Gate the decode so stale or uninitialised storage never leaks out.
  assign out_a     = out_valid ? head_dec : '0;
  assign req_count = req_q;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    req_d = req_q;
    if (push) wr_d = wr_q + 1'b1;
    if (pop)  rd_d = rd_q + 1'b1;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    if (pop && head != '0 && req_q != '1) begin
      req_d = req_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      req_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      req_q <= req_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= in_code;
  end

endmodule

// File: tb/tb_priority_decoder_fifo.sv
// Randomised and directed bench for priority_decoder_fifo.
// A queue model drives expectations; a second instance checks saturation.
module tb_priority_decoder_fifo;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [2:0] in_code;
  logic       out_ready;

  logic       in_ready, out_valid;
  logic [7:1] out_a;
  logic [7:0] req_count;

  logic       s_in_ready, s_out_valid;
  logic [7:1] s_out_a;
  logic [1:0] s_req_count;

  int n_vec = 0;
  int n_err = 0;

  int q[$];
  int cnt8 = 0;
  int cnt2 = 0;

  always #5 clk = ~clk;

  priority_decoder_fifo #(.DEPTH(DEPTH), .CNTW(8)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_code   (in_code),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_a     (out_a),
    .out_ready (out_ready),
    .req_count (req_count)
  );

  priority_decoder_fifo #(.DEPTH(DEPTH), .CNTW(2)) u_sat (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_code   (in_code),
    .in_ready  (s_in_ready),
    .out_valid (s_out_valid),
    .out_a     (s_out_a),
    .out_ready (out_ready),
    .req_count (s_req_count)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:1] ref_dec(int c);
    logic [7:1] r;
    r = '0;
    if (c != 0) r[c] = 1'b1;
    return r;
  endfunction

  function automatic int penc(logic [7:1] a);
    int e;
    e = 0;
    for (int k = 1; k <= 7; k++) if (a[k]) e = k;
    return e;
  endfunction

  task automatic cycle(input logic v, input int c,
                       input logic r, input logic rst);
    logic ev, er, push, pop;
    logic [7:1] ea;
    @(negedge clk);
    in_valid  = v;
    in_code   = 3'(c);
    out_ready = r;
    reset     = rst;
    #1;
    er = !rst && q.size() < DEPTH;
    ev = !rst && q.size() > 0;
    ea = ev ? ref_dec(q[0]) : 7'b0;
    chk("in_ready", 32'(in_ready), 32'(er));
    chk("out_valid", 32'(out_valid), 32'(ev));
    chk("out_a", 32'(out_a), 32'(ea));
    chk("req_count", 32'(req_count), 32'(cnt8));
    chk("sat_count", 32'(s_req_count), 32'(cnt2));
    chk("sat_out_a", 32'(s_out_a), 32'(ea));
    chk("sat_ready", 32'(s_in_ready), 32'(er));
    if (ev) chk("round_trip", 32'(penc(out_a)), 32'(q[0]));
    push = v && er;
    pop  = ev && r;
    @(posedge clk);
    if (rst) begin
      q.delete();
      cnt8 = 0;
      cnt2 = 0;
    end else begin
      if (pop) begin
        if (q[0] != 0) begin
          if (cnt8 < 255) cnt8++;
          if (cnt2 < 3) cnt2++;
        end
        void'(q.pop_front());
      end
      if (push) q.push_back(c);
    end
  endtask

  initial begin
    int pat [4];
    pat = '{7, 1, 0, 4};
    in_valid  = 1'b0;
    in_code   = '0;
    out_ready = 1'b0;
    reset     = 1'b1;

    cycle(0, 0, 0, 1);
    cycle(1, 3, 1, 1);

    foreach (pat[i]) cycle(1, pat[i], 0, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cycle(0, 0, 1, 0);

    cycle(1, 2, 0, 0);
    cycle(1, 3, 0, 0);
    for (int i = 0; i < 10; i++) cycle(1, (i % 7) + 1, 1, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0);

    for (int i = 0; i < 4; i++) cycle(1, i + 1, 0, 0);
    for (int i = 0; i < 3; i++) cycle(1, 5, 0, 0);
    cycle(1, 5, 1, 0);
    cycle(1, 5, 0, 0);
    for (int i = 0; i < 5; i++) cycle(0, 0, 1, 0);

    for (int i = 0; i < 3; i++) cycle(1, 6 - i, 0, 0);
    cycle(0, 0, 0, 1);
    cycle(1, 6, 0, 0);
    cycle(0, 0, 1, 0);
    cycle(0, 0, 1, 0);

    for (int c = 0; c < 8; c++) cycle(1, c, 1, 0);
    for (int i = 0; i < 5; i++) cycle(0, 0, 1, 0);

    for (int i = 0; i < 600; i++) begin
      cycle(1'($urandom_range(0, 3) != 0),
            int'($urandom_range(0, 7)),
            1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 60) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
